// File: rtl/sawtooth_sequencer.sv
// sawtooth_sequencer: steps a count N1..N2 on each tick strobe, with wrap/done/error reporting.
// Optional macro SAWTOOTH_SEQ_PAUSE_EN adds pause_i and the PAUSE state (code 5).
module sawtooth_sequencer #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             start_i,
    input  logic             stop_i,
`ifdef SAWTOOTH_SEQ_PAUSE_EN
    input  logic             pause_i,
`endif
    input  logic [WIDTH-1:0] n1_i,
    input  logic [WIDTH-1:0] n2_i,
    input  logic [REP_W-1:0] reps_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             busy_o,
    output logic             wrap_o,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       state_o
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4,
        S_PAUSE = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, n1_q, n1_d, n2_q, n2_d;
    logic [REP_W-1:0] reps_q, reps_d, per_q, per_d;
    logic             wrap_q, wrap_d, done_q, done_d;
    logic             busy_q, busy_d, err_q, err_d;
    logic             pause_w, at_top, last_period, load;

`ifdef SAWTOOTH_SEQ_PAUSE_EN
    assign pause_w = pause_i;
`else
    assign pause_w = 1'b0;
`endif

    // The compare against N2 happens before any increment, so the count never overflows.
    assign at_top      = (cnt_q == n2_q);
    assign last_period = (reps_q != '0) &&
                         (({1'b0, per_q} + {{REP_W{1'b0}}, 1'b1}) == {1'b0, reps_q});
    assign load        = ((state_q == S_IDLE) || (state_q == S_ERR)) && start_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_CHECK;
            S_CHECK: begin
                if (stop_i)           state_d = S_IDLE;
                else if (n1_q > n2_q) state_d = S_ERR;
                else                  state_d = S_RUN;
            end
            S_RUN: begin
                if (stop_i)                               state_d = S_IDLE;
                else if (pause_w)                         state_d = S_PAUSE;
                else if (ce_i && at_top && last_period)   state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   if (start_i) state_d = S_CHECK;
            S_PAUSE: begin
                if (stop_i)        state_d = S_IDLE;
                else if (!pause_w) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        n1_d   = n1_q;
        n2_d   = n2_q;
        reps_d = reps_q;
        per_d  = per_q;
        wrap_d = 1'b0;
        if (load) begin
            n1_d   = n1_i;
            n2_d   = n2_i;
            reps_d = reps_i;
            per_d  = '0;
        end
        if ((state_q == S_CHECK) && (state_d == S_RUN)) begin
            cnt_d = n1_q;
        end
        // A step only when staying in RUN: stop, pause and the final period end all exclude it.
        if ((state_q == S_RUN) && (state_d == S_RUN) && ce_i) begin
            if (!at_top) begin
                cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_d  = n1_q;
                wrap_d = 1'b1;
                if (per_q != '1) per_d = per_q + {{(REP_W-1){1'b0}}, 1'b1};
            end
        end
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
        busy_d = (state_d == S_CHECK) || (state_d == S_RUN) || (state_d == S_PAUSE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            n1_q   <= '0;
            n2_q   <= '0;
            reps_q <= '0;
            per_q  <= '0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            n1_q   <= n1_d;
            n2_q   <= n2_d;
            reps_q <= reps_d;
            per_q  <= per_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign busy_o  = busy_q;
    assign wrap_o  = wrap_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_sawtooth_sequencer.sv
// Self-checking bench for sawtooth_sequencer: per-cycle reference model plus directed literal checks.
// Directed pause checks are built only with SAWTOOTH_SEQ_PAUSE_EN.
module tb_sawtooth_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic [7:0] n1 = '0, n2 = '0;
    logic [3:0] reps = '0;
    logic [7:0] cnt_o;
    logic       busy_o, wrap_o, done_o, err_o;
    logic [2:0] state_o;

    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;
    int wrap_seen = 0, done_seen = 0, busy_low = 0;

    // reference model: spec-level run state
    int m_state, m_cnt, m_n1, m_n2, m_reps, m_periods;
    bit m_wrap;

    sawtooth_sequencer #(.WIDTH(8), .REP_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .start_i(start), .stop_i(stop),
`ifdef SAWTOOTH_SEQ_PAUSE_EN
        .pause_i(pause),
`endif
        .n1_i(n1), .n2_i(n2), .reps_i(reps),
        .cnt_o(cnt_o), .busy_o(busy_o), .wrap_o(wrap_o), .done_o(done_o),
        .err_o(err_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_n1 = 0; m_n2 = 0; m_reps = 0; m_periods = 0; m_wrap = 0;
    endtask

    task automatic model_latch();
        m_n1 = n1; m_n2 = n2; m_reps = reps; m_periods = 0; m_state = 1;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        m_wrap = 0;
        case (m_state)
            0: if (start) model_latch();
            1: begin
                if (stop) m_state = 0;
                else if (m_n1 > m_n2) m_state = 4;
                else begin m_cnt = m_n1; m_state = 2; end
            end
            2: begin
                if (stop) m_state = 0;
                else if (pause) m_state = 5;
                else if (ce) begin
                    if (m_cnt < m_n2) m_cnt = m_cnt + 1;
                    else if (m_reps != 0 && m_periods + 1 == m_reps) m_state = 3;
                    else begin m_cnt = m_n1; m_wrap = 1; m_periods++; end
                end
            end
            3: m_state = 0;
            4: if (start) model_latch();
            5: begin
                if (stop) m_state = 0;
                else if (!pause) m_state = 2;
            end
            default: m_state = 0;
        endcase
    endtask

    // compare process
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", state_o, m_state);
            check("cnt", cnt_o, m_cnt);
            check("busy", busy_o, (m_state == 1 || m_state == 2 || m_state == 5) ? 1 : 0);
            check("err", err_o, (m_state == 4) ? 1 : 0);
            check("done", done_o, (m_state == 3) ? 1 : 0);
            check("wrap", wrap_o, m_wrap ? 1 : 0);
            if (wrap_o) wrap_seen++;
            if (done_o) done_seen++;
            if (!busy_o) busy_low++;
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_ce();
        ce = 1'b1; step(); ce = 1'b0;
    endtask

    task automatic do_start(input int a, input int b, input int r);
        n1 = 8'(a); n2 = 8'(b); reps = 4'(r);
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic clr_counts();
        wrap_seen = 0; done_seen = 0; busy_low = 0;
    endtask

    int obs[6];
    int exp2[6] = '{3, 4, 5, 3, 4, 5};

    initial begin
        model_reset();
        idle(2);
        check("reset_state", state_o, 0);
        check("reset_cnt", cnt_o, 0);
        check("reset_flags", {busy_o, wrap_o, done_o, err_o}, 0);
        rst = 1'b0;
        chk_en = 1;
        step();

        // async reset mid-run at cnt 7
        do_start(0, 20, 0);
        step();
        for (int i = 0; i < 7; i++) pulse_ce();
        check("t1_cnt_before", cnt_o, 7);
        #2 rst = 1'b1;
        #1;
        check("t1_cnt", cnt_o, 0);
        check("t1_state", state_o, 0);
        check("t1_flags", {busy_o, wrap_o, done_o, err_o}, 0);
        model_reset();
        step();
        rst = 1'b0;
        step();

        // 3..5 twice
        clr_counts();
        do_start(3, 5, 2);
        step();
        obs[0] = cnt_o;
        for (int k = 1; k < 6; k++) begin
            pulse_ce();
            obs[k] = cnt_o;
            idle(3);
        end
        for (int k = 0; k < 6; k++) check($sformatf("t2_seq%0d", k), obs[k], exp2[k]);
        pulse_ce();
        check("t2_done", done_o, 1);
        check("t2_cnt_end", cnt_o, 5);
        step();
        step();
        check("t2_idle", state_o, 0);
        check("t2_wraps", wrap_seen, 1);
        check("t2_dones", done_seen, 1);

        // error path then recovery
        do_start(9, 4, 0);
        check("t3_check", state_o, 1);
        step();
        check("t3_err_state", state_o, 4);
        check("t3_err", err_o, 1);
        check("t3_cnt_held", cnt_o, 5);
        check("t3_busy", busy_o, 0);
        do_start(1, 2, 0);
        step();
        check("t3_run", state_o, 2);
        check("t3_err_clr", err_o, 0);
        stop = 1'b1; step(); stop = 1'b0;

        // full range, infinite reps
        do_start(0, 255, 0);
        step();
        clr_counts();
        for (int i = 0; i < 300; i++) begin
            pulse_ce();
            step();
        end
        step();
        check("t4_cnt", cnt_o, 44);
        check("t4_wraps", wrap_seen, 1);
        check("t4_dones", done_seen, 0);
        check("t4_busy_low", busy_low, 0);
        stop = 1'b1; step(); stop = 1'b0;

        // start ignored in RUN, stop beats ce
        do_start(2, 9, 1);
        step();
        pulse_ce();
        pulse_ce();
        start = 1'b1; step(); start = 1'b0;
        check("t5_start_ign", state_o, 2);
        clr_counts();
        stop = 1'b1; ce = 1'b1; step(); stop = 1'b0; ce = 1'b0;
        check("t5_state", state_o, 0);
        check("t5_cnt", cnt_o, 4);
        step();
        check("t5_wraps", wrap_seen, 0);
        check("t5_dones", done_seen, 0);

`ifdef SAWTOOTH_SEQ_PAUSE_EN
        do_start(0, 20, 0);
        step();
        for (int i = 0; i < 6; i++) pulse_ce();
        pause = 1'b1;
        step();
        for (int i = 0; i < 10; i++) pulse_ce();
        check("t6_pause_state", state_o, 5);
        check("t6_pause_cnt", cnt_o, 6);
        pause = 1'b0;
        step();
        pulse_ce();
        check("t6_resume_cnt", cnt_o, 7);
        stop = 1'b1; step(); stop = 1'b0;
`endif

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            ce    = $urandom_range(0, 1);
`ifdef SAWTOOTH_SEQ_PAUSE_EN
            pause = ($urandom_range(0, 9) == 0);
`endif
            if ($urandom_range(0, 9) == 0) begin
                n1 = 8'($urandom_range(0, 255));
                n2 = 8'($urandom_range(0, 255));
            end else begin
                n1 = 8'($urandom_range(0, 7));
                n2 = 8'($urandom_range(0, 7));
            end
            reps = 4'($urandom_range(0, 3));
            step();
        end
        start = 1'b0; stop = 1'b0; ce = 1'b0; pause = 1'b0;
        step();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
